// File: rtl/wb_pingpong_sink.sv
// wb_pingpong_sink: Wishbone-style write sink with a two-bank ping-pong buffer.
// A bank fills with COUNT words and is then handed to the consumer read port
// while the writer moves on to the other bank.
// Optional build macro WB_PINGPONG_SINK_STATS_EN adds frame and stall counters.
//
// Read-port FSM:
//   state      | meaning
//   RD_IDLE    | no full bank offered, r_rdy_o = 0
//   RD_PRESENT | full bank r_bank_o offered, r_rdy_o = 1
// Per-bank state is tracked with a single full flag. A bank is EMPTY when the
// flag is clear, FILLING when it is also the write bank with wcnt != 0, and
// FULL when the flag is set.

module wb_pingpong_sink #(
   parameter int WIDTH = 32,
   parameter int SBITS = 10,
   parameter int COUNT = 576
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             s_cyc_i,
   input  logic             s_stb_i,
   input  logic             s_we_i,
   input  logic             s_bst_i,
   output logic             s_ack_o,
   output logic             s_wat_o,
   output logic             s_err_o,
   input  logic [SBITS-1:0] s_adr_i,
   input  logic [WIDTH-1:0] s_dat_i,
   output logic             r_rdy_o,
   output logic             r_bank_o,
   input  logic [SBITS-1:0] r_adr_i,
   output logic [WIDTH-1:0] r_dat_o,
   input  logic             r_done_i
`ifdef WB_PINGPONG_SINK_STATS_EN
   ,
   output logic [15:0]      frames_o,
   output logic [15:0]      stalls_o
`endif
);

   localparam int DEPTH = 1 << SBITS;
   localparam logic [SBITS:0] COUNT_W = (SBITS+1)'(COUNT);
   localparam logic [SBITS:0] LAST_W  = (SBITS+1)'(COUNT - 1);

   typedef enum logic {RD_IDLE, RD_PRESENT} rd_state_t;

   rd_state_t        rd_state, rd_state_nxt;
   logic             r_bank_nxt;
   logic             release_bank;
   logic [1:0]       bank_full, bank_full_nxt;
   logic             wbank;
   logic [SBITS:0]   wcnt;
   logic             req, adr_ok, accept, bad_req, frame_done;
   logic [WIDTH-1:0] mem [2*DEPTH];

   // Burst hint needs no special handling: every accepted strobe is acked.
   logic unused_bst;
   assign unused_bst = s_bst_i;

   assign req        = s_cyc_i & s_stb_i;
   assign adr_ok     = {1'b0, s_adr_i} < COUNT_W;
   assign bad_req    = req & (~s_we_i | ~adr_ok);
   assign accept     = req & s_we_i & adr_ok & ~bank_full[wbank];
   assign s_wat_o    = req & s_we_i & adr_ok & bank_full[wbank];
   assign frame_done = accept & (wcnt == LAST_W);
   assign r_rdy_o    = (rd_state == RD_PRESENT);

   // Read-port next state; a bank completing this cycle counts as full so the
   // hand-over on r_done_i has no r_rdy_o gap.
   always_comb begin
      rd_state_nxt = rd_state;
      r_bank_nxt   = r_bank_o;
      release_bank = 1'b0;
      case (rd_state)
         RD_IDLE: begin
            if (|bank_full) begin
               rd_state_nxt = RD_PRESENT;
               // With both full, the write pointer sits on the older bank.
               r_bank_nxt   = (&bank_full) ? wbank : bank_full[1];
            end
         end
         RD_PRESENT: begin
            if (r_done_i) begin
               release_bank = 1'b1;
               if (bank_full[~r_bank_o] | (frame_done & (wbank == ~r_bank_o)))
                  r_bank_nxt = ~r_bank_o;
               else
                  rd_state_nxt = RD_IDLE;
            end
         end
         default: rd_state_nxt = RD_IDLE;
      endcase
   end

   // Bank flags: fill and release never target the same bank in one cycle.
   always_comb begin
      bank_full_nxt = bank_full;
      if (frame_done)   bank_full_nxt[wbank]    = 1'b1;
      if (release_bank) bank_full_nxt[r_bank_o] = 1'b0;
   end

   // Read-port state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rd_state <= RD_IDLE;
         r_bank_o <= 1'b0;
      end else begin
         rd_state <= rd_state_nxt;
         r_bank_o <= r_bank_nxt;
      end
   end

   // Write side: handshake responses, word counter, bank pointer and flags.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s_ack_o   <= 1'b0;
         s_err_o   <= 1'b0;
         wbank     <= 1'b0;
         wcnt      <= '0;
         bank_full <= 2'b00;
      end else begin
         s_ack_o   <= accept;
         s_err_o   <= bad_req;
         bank_full <= bank_full_nxt;
         if (frame_done) begin
            wcnt  <= '0;
            wbank <= ~wbank;
         end else if (accept) begin
            wcnt  <= wcnt + 1'b1;
         end
      end
   end

   // Buffer storage; contents survive reset, read data lags the address by one cycle.
   always_ff @(posedge clk_i) begin
      if (accept) mem[{wbank, s_adr_i}] <= s_dat_i;
      r_dat_o <= mem[{r_bank_o, r_adr_i}];
   end

`ifdef WB_PINGPONG_SINK_STATS_EN
   // Frame counter wraps; stall counter saturates.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         frames_o <= '0;
         stalls_o <= '0;
      end else begin
         if (frame_done) frames_o <= frames_o + 16'd1;
         if (s_wat_o && (stalls_o != 16'hFFFF)) stalls_o <= stalls_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_pingpong_sink.sv
// Directed bench for wb_pingpong_sink (COUNT = 576, SBITS = 10, WIDTH = 32).
module tb_wb_pingpong_sink;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc, stb, we, bst;
   logic        ack, wat, err;
   logic [9:0]  adr;
   logic [31:0] dat;
   logic        rdy, rbank;
   logic [9:0]  radr;
   logic [31:0] rdat;
   logic        rdone;
`ifdef WB_PINGPONG_SINK_STATS_EN
   logic [15:0] frames, stalls;
`endif

   int pass = 0;
   int chk  = 0;

   always #5 clk = ~clk;

   wb_pingpong_sink #(.WIDTH(32), .SBITS(10), .COUNT(576)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .s_cyc_i  (cyc),
      .s_stb_i  (stb),
      .s_we_i   (we),
      .s_bst_i  (bst),
      .s_ack_o  (ack),
      .s_wat_o  (wat),
      .s_err_o  (err),
      .s_adr_i  (adr),
      .s_dat_i  (dat),
      .r_rdy_o  (rdy),
      .r_bank_o (rbank),
      .r_adr_i  (radr),
      .r_dat_o  (rdat),
      .r_done_i (rdone)
`ifdef WB_PINGPONG_SINK_STATS_EN
      ,
      .frames_o (frames),
      .stalls_o (stalls)
`endif
   );

   task automatic bus_idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; bst = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus_idle();
      rdone = 1'b0; radr = '0; adr = '0; dat = '0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Back-to-back writes adr=start+i, dat=base+start+i; counts acks seen.
   task automatic burst(input int start, input int n, input int base, output int acks);
      acks = 0;
      for (int i = 0; i < n; i++) begin
         cyc = 1'b1; stb = 1'b1; we = 1'b1; bst = (i < n - 1);
         adr = 10'(start + i);
         dat = 32'(base + start + i);
         tick();
         if (ack) acks++;
      end
      bus_idle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_idle();
      rdone = 1'b0; radr = '0; adr = '0; dat = '0;
      tick(); tick();
      chk++; if ({ack, wat, err, rdy, rbank} !== 5'b0)
         $display("FAIL reset_outs: got %b want 00000", {ack, wat, err, rdy, rbank}); else pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_single_frame();
      int acks;
      do_reset();
      burst(0, 576, 0, acks);
      chk++; if (acks !== 576) $display("FAIL t1_acks: got %0d want 576", acks); else pass++;
      chk++; if (rdy !== 1'b0) $display("FAIL t1_rdy_early: got %b want 0", rdy); else pass++;
      tick();
      chk++; if (ack !== 1'b0) $display("FAIL t1_ack_single: got %b want 0", ack); else pass++;
      chk++; if (rdy !== 1'b1) $display("FAIL t1_rdy: got %b want 1", rdy); else pass++;
      chk++; if (rbank !== 1'b0) $display("FAIL t1_bank: got %b want 0", rbank); else pass++;
      radr = 10'd100;
      tick();
      chk++; if (rdat !== 32'd100) $display("FAIL t1_rdat: got %0d want 100", rdat); else pass++;
      rdone = 1'b1; tick(); rdone = 1'b0;
      chk++; if (rdy !== 1'b0) $display("FAIL t1_release: got %b want 0", rdy); else pass++;
   endtask

   task automatic test_wait();
      int acks;
      do_reset();
      burst(0, 576, 1000, acks);
      burst(0, 576, 2000, acks);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 10'd5; dat = 32'd3005;
      #1;
      chk++; if (wat !== 1'b1) $display("FAIL t2_wat: got %b want 1", wat); else pass++;
      tick();
      tick();
      chk++; if (ack !== 1'b0) $display("FAIL t2_no_ack: got %b want 0", ack); else pass++;
      chk++; if ({rdy, rbank} !== 2'b10) $display("FAIL t2_present0: got %b want 10", {rdy, rbank}); else pass++;
      radr = 10'd7;
      tick();
      chk++; if (rdat !== 32'd1007) $display("FAIL t2_rdat0: got %0d want 1007", rdat); else pass++;
      rdone = 1'b1;
      tick();
      rdone = 1'b0;
      chk++; if ({rdy, rbank} !== 2'b11) $display("FAIL t2_present1: got %b want 11", {rdy, rbank}); else pass++;
      chk++; if ({ack, wat} !== 2'b00) $display("FAIL t2_freed: ack/wat got %b want 00", {ack, wat}); else pass++;
      tick();
      chk++; if (ack !== 1'b1) $display("FAIL t2_resume_ack: got %b want 1", ack); else pass++;
      bus_idle();
      tick();
      chk++; if (rdat !== 32'd2007) $display("FAIL t2_rdat1: got %0d want 2007", rdat); else pass++;
   endtask

   task automatic test_error();
      int acks;
      do_reset();
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 10'd3; dat = 32'hDEAD;
      tick();
      chk++; if ({err, ack} !== 2'b10) $display("FAIL t3_err_read: err/ack got %b want 10", {err, ack}); else pass++;
      we = 1'b1; adr = 10'd600;
      tick();
      chk++; if ({err, ack} !== 2'b10) $display("FAIL t3_err_600: err/ack got %b want 10", {err, ack}); else pass++;
      adr = 10'd576;
      tick();
      chk++; if ({err, ack} !== 2'b10) $display("FAIL t3_err_576: err/ack got %b want 10", {err, ack}); else pass++;
      bus_idle();
      tick();
      chk++; if (err !== 1'b0) $display("FAIL t3_err_clear: got %b want 0", err); else pass++;
      burst(0, 575, 0, acks);
      tick(); tick();
      chk++; if (rdy !== 1'b0) $display("FAIL t3_count_kept: rdy got %b want 0", rdy); else pass++;
      burst(575, 1, 0, acks);
      chk++; if (acks !== 1) $display("FAIL t3_last_ack: got %0d want 1", acks); else pass++;
      tick();
      chk++; if (rdy !== 1'b1) $display("FAIL t3_rdy: got %b want 1", rdy); else pass++;
   endtask

   task automatic test_simul_done();
      int acks;
      do_reset();
      burst(0, 576, 0, acks);
      burst(0, 575, 5000, acks);
      chk++; if ({rdy, rbank} !== 2'b10) $display("FAIL t4_pre: got %b want 10", {rdy, rbank}); else pass++;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 10'd575; dat = 32'd5575;
      rdone = 1'b1;
      tick();
      rdone = 1'b0;
      chk++; if (ack !== 1'b1) $display("FAIL t4_ack: got %b want 1", ack); else pass++;
      chk++; if ({rdy, rbank} !== 2'b11) $display("FAIL t4_handover: got %b want 11", {rdy, rbank}); else pass++;
      adr = 10'd0; dat = 32'd7777;
      #1;
      chk++; if (wat !== 1'b0) $display("FAIL t4_wat: got %b want 0", wat); else pass++;
      tick();
      chk++; if (ack !== 1'b1) $display("FAIL t4_resume: got %b want 1", ack); else pass++;
      bus_idle();
      radr = 10'd575;
      tick();
      chk++; if (rdat !== 32'd5575) $display("FAIL t4_rdat: got %0d want 5575", rdat); else pass++;
      chk++; if ({rdy, rbank} !== 2'b11) $display("FAIL t4_hold: got %b want 11", {rdy, rbank}); else pass++;
   endtask

   task automatic test_reset_mid();
      int acks;
      do_reset();
      burst(0, 576, 0, acks);
      burst(0, 300, 100, acks);
      rst_n = 1'b0;
      tick();
      chk++; if ({ack, wat, err, rdy, rbank} !== 5'b0)
         $display("FAIL t5_reset_outs: got %b want 00000", {ack, wat, err, rdy, rbank}); else pass++;
      rst_n = 1'b1;
      burst(0, 575, 9000, acks);
      tick(); tick();
      chk++; if (rdy !== 1'b0) $display("FAIL t5_no_early: rdy got %b want 0", rdy); else pass++;
      burst(575, 1, 9000, acks);
      tick();
      chk++; if ({rdy, rbank} !== 2'b10) $display("FAIL t5_present0: got %b want 10", {rdy, rbank}); else pass++;
      radr = 10'd575;
      tick();
      chk++; if (rdat !== 32'd9575) $display("FAIL t5_rdat575: got %0d want 9575", rdat); else pass++;
      radr = 10'd10;
      tick();
      chk++; if (rdat !== 32'd9010) $display("FAIL t5_rdat10: got %0d want 9010", rdat); else pass++;
   endtask

`ifdef WB_PINGPONG_SINK_STATS_EN
   task automatic test_stats();
      int acks;
      do_reset();
      chk++; if ({frames, stalls} !== 32'd0) $display("FAIL t6_reset: got %h want 0", {frames, stalls}); else pass++;
      burst(0, 576, 0, acks);
      burst(0, 576, 0, acks);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 10'd0; dat = 32'd1;
      for (int i = 0; i < 10; i++) tick();
      bus_idle();
      rdone = 1'b1; tick(); rdone = 1'b0;
      burst(0, 576, 0, acks);
      tick();
      chk++; if (frames !== 16'd3) $display("FAIL t6_frames: got %0d want 3", frames); else pass++;
      chk++; if (stalls !== 16'd10) $display("FAIL t6_stalls: got %0d want 10", stalls); else pass++;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single_frame();
      test_wait();
      test_error();
      test_simul_done();
      test_reset_mid();
`ifdef WB_PINGPONG_SINK_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

endmodule
